// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared audio-path types and widths
// Used by the recorder, playback DSP and SRAM controller.
package aud_pkg;

    localparam int AUD_ADDR_W = 20;
    localparam int AUD_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SHIFT,
        WRITE,
        PAUSE,
        FULL
    } rec_state_t;

endpackage

// File: rtl/aud_rec_writer_if.sv
// rtl/aud_rec_writer_if.sv - SRAM write port driven by the recorder
// Master drives address/data/strobe; the SRAM controller samples on the strobe edge.
interface aud_rec_writer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data;
    logic              sram_we;

    modport master (output sram_addr, output sram_data, output sram_we);
    modport slave  (input  sram_addr, input  sram_data, input  sram_we);
endinterface

// File: rtl/aud_i2s_lrx.sv
// rtl/aud_i2s_lrx.sv - I2S left-channel receiver
// Synchronises the codec pins, finds BCLK rises, skips the delay slot and shifts DATA_W bits MSB first.
module aud_i2s_lrx #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bclk,
    input  logic              i_lrck,
    input  logic              i_dat,
    input  logic              i_en,
    input  logic              i_abort,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_word,
    output logic              o_in_frame
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [1:0]        r_bclk_sync;
    logic [1:0]        r_lrck_sync;
    logic [1:0]        r_dat_sync;
    logic              r_bclk_d;
    logic              r_lrck_prev;
    logic              r_in_frame;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              w_rise;

    assign w_rise     = r_bclk_sync[1] & ~r_bclk_d;
    assign o_valid    = r_valid;
    assign o_word     = r_shreg;
    assign o_in_frame = r_in_frame;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
            r_lrck_prev <= 1'b1;
            r_in_frame  <= 1'b0;
            r_valid     <= 1'b0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], i_bclk};
            r_lrck_sync <= {r_lrck_sync[0], i_lrck};
            r_dat_sync  <= {r_dat_sync[0], i_dat};
            r_bclk_d    <= r_bclk_sync[1];
            r_valid     <= 1'b0;
            if (w_rise) begin
                r_lrck_prev <= r_lrck_sync[1];
            end
            if (!i_en || i_abort) begin
                r_in_frame <= 1'b0;
                r_bit_cnt  <= '0;
            end else if (w_rise) begin
                if (!r_in_frame) begin
                    // LRCK fell since the previous rise: this rise is the delay slot
                    if (r_lrck_prev && !r_lrck_sync[1]) begin
                        r_in_frame <= 1'b1;
                        r_bit_cnt  <= '0;
                    end
                end else begin
                    r_shreg <= {r_shreg[DATA_W-2:0], r_dat_sync[1]};
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        r_in_frame <= 1'b0;
                        r_valid    <= 1'b1;
                        r_bit_cnt  <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/aud_rec_writer.sv
// rtl/aud_rec_writer.sv - records the codec left channel into SRAM from address 0
// Owns addressing, record/pause/stop control and the recorded-length report.
module aud_rec_writer
    import aud_pkg::*;
#(
    parameter int          ADDR_W   = AUD_ADDR_W,
    parameter int          DATA_W   = AUD_DATA_W,
    parameter int unsigned MAX_ADDR = 2**ADDR_W - 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_adc_bclk,
    input  logic              i_adc_lrck,
    input  logic              i_adc_dat,
    aud_rec_writer_if.master  o_sram,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_busy,
    output logic              o_full
);
    rec_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic [ADDR_W:0]   r_rec_len;
    logic              r_busy;
    logic              r_full;
    logic              r_pend_stop;
    logic              r_pend_pause;

    logic              w_valid;
    logic [DATA_W-1:0] w_word;
    logic              w_in_frame;
    logic              w_en;
    logic              w_abort;

    assign w_en    = (r_state == WAIT) || (r_state == SHIFT);
    assign w_abort = w_en && (i_stop || i_pause) && !w_valid;

    aud_i2s_lrx #(.DATA_W(DATA_W)) u_lrx (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_bclk     (i_adc_bclk),
        .i_lrck     (i_adc_lrck),
        .i_dat      (i_adc_dat),
        .i_en       (w_en),
        .i_abort    (w_abort),
        .o_valid    (w_valid),
        .o_word     (w_word),
        .o_in_frame (w_in_frame)
    );

    assign o_sram.sram_addr = r_addr;
    assign o_sram.sram_data = r_data;
    assign o_sram.sram_we   = r_we;
    assign o_rec_len        = r_rec_len;
    assign o_busy           = r_busy;
    assign o_full           = r_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_rec_len    <= '0;
            r_busy       <= 1'b0;
            r_full       <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_pend_pause <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE, FULL: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                        r_full  <= 1'b0;
                    end else if (i_start && !i_pause) begin
                        r_state   <= WAIT;
                        r_addr    <= '0;
                        r_rec_len <= '0;
                        r_busy    <= 1'b1;
                        r_full    <= 1'b0;
                    end
                end
                WAIT, SHIFT: begin
                    // A completed sample always commits; a coinciding stop/pause is deferred past the strobe
                    if (w_valid) begin
                        r_state      <= WRITE;
                        r_we         <= 1'b1;
                        r_data       <= w_word;
                        r_pend_stop  <= i_stop;
                        r_pend_pause <= i_pause;
                    end else if (i_stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_pause) begin
                        r_state <= PAUSE;
                        r_busy  <= 1'b0;
                    end else if (r_state == WAIT && w_in_frame) begin
                        r_state <= SHIFT;
                    end
                end
                WRITE: begin
                    r_rec_len    <= {1'b0, r_addr} + (ADDR_W+1)'(1);
                    r_pend_stop  <= 1'b0;
                    r_pend_pause <= 1'b0;
                    if (i_stop || r_pend_stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_addr == ADDR_W'(MAX_ADDR)) begin
                        r_state <= FULL;
                        r_busy  <= 1'b0;
                        r_full  <= 1'b1;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (i_pause || r_pend_pause) begin
                            r_state <= PAUSE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                PAUSE: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else if (i_start && !i_pause) begin
                        r_state <= WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_full  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aud_rec_writer.sv
// tb/tb_aud_rec_writer.sv - scoreboard bench for aud_rec_writer
// Memory is shrunk to four words so the FULL behaviour is reachable.
module tb_aud_rec_writer;
    import aud_pkg::*;

    localparam int ADDR_W   = AUD_ADDR_W;
    localparam int DATA_W   = AUD_DATA_W;
    localparam int MAX_ADDR = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop  = 1'b0;
    logic bclk  = 1'b1;
    logic lrck  = 1'b1;
    logic dat   = 1'b0;
    logic [ADDR_W:0] rec_len;
    logic busy;
    logic full;

    aud_rec_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram_if ();

    aud_rec_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(MAX_ADDR)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_adc_bclk (bclk),
        .i_adc_lrck (lrck),
        .i_adc_dat  (dat),
        .o_sram     (sram_if),
        .o_rec_len  (rec_len),
        .o_busy     (busy),
        .o_full     (full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc = 0;
    int unsigned lsb_cyc = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int addr, input logic [15:0] data);
        exp_q.push_back({ADDR_W'(addr), data});
    endtask

    // Monitor: compares every strobe against the scoreboard, then the cycle after it
    logic post_chk = 1'b0;
    logic [ADDR_W:0] exp_len;
    logic [ADDR_W+DATA_W-1:0] e;
    always @(negedge clk) begin
        if (post_chk) begin
            check("we_one_cycle", 64'(sram_if.sram_we), 64'd0);
            check("rec_len_after_we", 64'(rec_len), 64'(exp_len));
            post_chk = 1'b0;
        end else if (sram_if.sram_we) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_we: got strobe addr 0x%0h data 0x%0h, expected no strobe",
                         sram_if.sram_addr, sram_if.sram_data);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", 64'(sram_if.sram_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("we_data", 64'(sram_if.sram_data), 64'(e[DATA_W-1:0]));
                check("we_latency", 64'(cyc - lsb_cyc), 64'd4);
                check("rec_len_during_we", 64'(rec_len), 64'({1'b0, e[ADDR_W+DATA_W-1:DATA_W]}));
                exp_len  = {1'b0, e[ADDR_W+DATA_W-1:DATA_W]} + (ADDR_W+1)'(1);
                post_chk = 1'b1;
            end
        end
    end

    task automatic bclk_cyc(input logic lr, input logic d, input bit mark);
        bclk = 1'b0;
        lrck = lr;
        dat  = d;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        if (mark) lsb_cyc = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic bits(input logic lr, input logic [15:0] w, input int from, input int to);
        for (int i = from; i < to; i++) bclk_cyc(lr, w[15-i], (lr == 1'b0) && (i == 15));
    endtask

    task automatic half(input logic lr, input logic [15:0] w);
        bclk_cyc(lr, 1'b0, 1'b0);
        bits(lr, w, 0, 16);
        bclk_cyc(lr, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [15:0] l);
        half(1'b0, l);
        half(1'b1, 16'hAAAA);
    endtask

    task automatic rest_frame(input logic [15:0] l, input int from);
        bits(1'b0, l, from, 16);
        bclk_cyc(1'b0, 1'b0, 1'b0);
        half(1'b1, 16'hAAAA);
    endtask

    task automatic pulse(input bit s, input bit p, input bit t);
        start = s;
        pause = p;
        stop  = t;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"},    64'(sram_if.sram_addr), 64'd0);
        check({tag, "_data"},    64'(sram_if.sram_data), 64'd0);
        check({tag, "_we"},      64'(sram_if.sram_we),   64'd0);
        check({tag, "_rec_len"}, 64'(rec_len),           64'd0);
        check({tag, "_busy"},    64'(busy),              64'd0);
        check({tag, "_full"},    64'(full),              64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic record; right channel 0xAAAA must never appear
        pulse(1, 0, 0);
        push(0, 16'h8001); frame(16'h8001);
        push(1, 16'h1234); frame(16'h1234);
        push(2, 16'hFFFF); frame(16'hFFFF);
        check("basic_rec_len", 64'(rec_len), 64'd3);
        check("basic_busy", 64'(busy), 64'd1);

        // Pause after 8 bits of the 4th sample, then resume
        bclk_cyc(1'b0, 1'b0, 1'b0);
        bits(1'b0, 16'h7777, 0, 8);
        pulse(0, 1, 0);
        check("pause_busy", 64'(busy), 64'd0);
        rest_frame(16'h7777, 8);
        frame(16'h1111);
        check("pause_rec_len", 64'(rec_len), 64'd3);
        pulse(1, 0, 0);
        push(3, 16'h5A5A); frame(16'h5A5A);
        check("resume_rec_len", 64'(rec_len), 64'd4);
        check("resume_full", 64'(full), 64'd1);

        // Fresh recording of six samples; only four fit
        pulse(1, 0, 0);
        check("refill_rec_len_clear", 64'(rec_len), 64'd0);
        push(0, 16'h0001); frame(16'h0001);
        push(1, 16'h0202); frame(16'h0202);
        push(2, 16'h3003); frame(16'h3003);
        push(3, 16'h4444); frame(16'h4444);
        frame(16'h5555);
        frame(16'h6666);
        check("full_flag", 64'(full), 64'd1);
        check("full_busy", 64'(busy), 64'd0);
        check("full_rec_len", 64'(rec_len), 64'd4);

        // Start from FULL begins again at address 0
        pulse(1, 0, 0);
        push(0, 16'h0F0F); frame(16'h0F0F);
        check("restart_rec_len", 64'(rec_len), 64'd1);
        check("restart_full", 64'(full), 64'd0);

        // Pause and stop together mid-sample: stop wins, length is kept
        bclk_cyc(1'b0, 1'b0, 1'b0);
        bits(1'b0, 16'hBEEF, 0, 5);
        pulse(0, 1, 1);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_full", 64'(full), 64'd0);
        rest_frame(16'hBEEF, 5);
        frame(16'h1357);
        check("stop_rec_len_hold", 64'(rec_len), 64'd1);
        pulse(1, 0, 0);
        check("stop_restart_rec_len", 64'(rec_len), 64'd0);
        push(0, 16'hC3C3); frame(16'hC3C3);

        // Asynchronous reset with 9 bits of a sample captured
        bclk_cyc(1'b0, 1'b0, 1'b0);
        bits(1'b0, 16'hDEAD, 0, 9);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rest_frame(16'hDEAD, 9);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        pulse(1, 0, 0);
        push(0, 16'h2468); frame(16'h2468);
        check("post_rst_rec_len", 64'(rec_len), 64'd1);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aud_rec_writer.md
# aud_rec_writer

Recording-side counterpart of the playback DSP path. Deserialises the left channel of the WM8731 ADC I2S stream (BCLK/ADCLRCK/ADCDAT) and writes each 16-bit sample to consecutive SRAM addresses from 0. Reports the recorded length so playback knows where to stop. Sits between the codec pins and the SRAM controller's write port, and shares the record/pause/stop controls from the top FSM.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width; bits captured per left frame
- MAX_ADDR, 2**ADDR_W-1, last writable address
- i_clk  in  1  system clock; frequency must be at least 4× BCLK
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse; starts a new recording from IDLE/FULL, or resumes from PAUSE
- i_pause  in  1  one-cycle pulse; pause
- i_stop  in  1  one-cycle pulse; end recording
- i_adc_bclk  in  1  codec bit clock, asynchronous
- i_adc_lrck  in  1  codec ADC LR clock, asynchronous; low = left
- i_adc_dat  in  1  codec serial data, asynchronous
- o_sram_addr  out  ADDR_W  write address
- o_sram_data  out  DATA_W  write data
- o_sram_we  out  1  one-cycle write strobe, active-high
- o_rec_len  out  ADDR_W+1  number of samples written in the current recording
- o_busy  out  1  high in WAIT/SHIFT/WRITE
- o_full  out  1  high in FULL

## Operation
- The three codec inputs each pass through a 2-flop synchroniser. BCLK rising edge is detected by comparing the synchronised value with a delayed copy. All capture happens on the i_clk cycle that carries a detected BCLK rise (`rise`).
- States: IDLE, WAIT, SHIFT, WRITE, PAUSE, FULL.
- IDLE:
  - On i_start: addr←0, rec_len←0, go to WAIT.
- WAIT:
  - On `rise` with lrck_prev=1 and lrck=0: this is the I2S delay slot. Clear bit_cnt and go to SHIFT.
  - lrck_prev updates on every `rise`.
- SHIFT:
  - On each `rise`: shreg←{shreg[DATA_W-2:0],dat}, MSB first, and bit_cnt++.
  - After the DATA_W-th bit: go to WRITE.
  - Right-channel bits are never captured.
- WRITE (exactly 1 cycle): o_sram_we=1, o_sram_data=shreg, o_sram_addr=addr.
  - Next cycle: rec_len←addr+1.
  - If addr==MAX_ADDR, go to FULL. Otherwise addr←addr+1 and go to WAIT.
- PAUSE:
  - On i_start: go to WAIT. addr and rec_len are kept.
- FULL:
  - Ignores the codec.
  - On i_start: fresh recording (as in IDLE).
  - On i_stop: go to IDLE.
- Control priority: stop > pause > start.
  - i_stop in any state goes to IDLE and keeps rec_len. Addr is reset on the next start.
  - i_pause in WAIT/SHIFT goes to PAUSE and discards the partial sample.
  - i_start in WAIT/SHIFT/WRITE is ignored.
- A sample is committed once its DATA_W-th bit is captured. Stop/pause asserted in the WRITE cycle do not cancel the strobe; they take effect in the following cycle.
- rec_len is ADDR_W+1 bits wide, so a full memory reports 2**ADDR_W.

## Timing
- Reset values: o_sram_addr=0, o_sram_data=0, o_sram_we=0, o_rec_len=0, o_busy=0, o_full=0; state=IDLE; shreg, bit_cnt, lrck_prev = 0/1 (lrck_prev=1).
- Reset asserted mid-SHIFT or mid-WRITE: all outputs return to reset values asynchronously, and no strobe completes.
- All outputs are registered.
- BCLK pin rise → `rise` takes 3 i_clk cycles (2 sync + edge register).
- Last data bit captured → o_sram_we high on the next i_clk edge. Total latency from the pin: 4 i_clk cycles.
- o_sram_we is never high on two consecutive cycles. Between strobes there is at least one full LRCK frame.
- o_sram_addr/data are stable during the strobe cycle. The SRAM controller samples them on the strobe edge.
- o_rec_len updates in the cycle after the strobe.

## Structure
- Shared package aud_pkg:
  - state enum rec_state_t {IDLE, WAIT, SHIFT, WRITE, PAUSE, FULL}
  - constants AUD_ADDR_W=20 and AUD_DATA_W=16, also used by the playback DSP and SRAM controller
- Sub-module aud_i2s_lrx: synchroniser, edge detect, delay-slot handling and shift register. Outputs: sample valid pulse and sample word. It takes an enable and an abort input from the parent FSM. The parent keeps the addressing and control FSM.

## Test plan
- Reset mid-frame: i_rst pulsed while SHIFT has 9 bits captured → all outputs 0 immediately, no o_sram_we. A later i_start records normally from addr 0.
- Basic record: i_start, then left samples 0x8001, 0x1234, 0xFFFF (right channel 0xAAAA) → strobes at addr 0, 1, 2 with exactly those data; 0xAAAA is never written; o_rec_len=3; o_busy=1.
- Pause mid-sample: pause after 8 bits of the 4th left sample → no strobe, o_busy=0. i_start → next complete left sample (0x5A5A) is written at addr 3, o_rec_len=4.
- Full: MAX_ADDR=3, record 6 samples → 4 strobes at addr 0-3, o_full=1, o_busy=0, o_rec_len=4, no further strobes. i_start → new recording at addr 0.
- Stop/restart and priority: i_pause and i_stop in the same cycle during SHIFT → IDLE, o_rec_len holds its value. i_start → o_rec_len=0 and the next write goes to addr 0.
- Timing: check that o_sram_we rises exactly 4 i_clk after the BCLK pin rise carrying the LSB, lasts 1 cycle, and that o_rec_len changes one cycle later.
